rect_scan_gen: RTL and testbench
================================

Name: rect_scan_gen

Overview:
- Parametrised raster-scan coordinate generator for the VGA plotting path.
- Loads a rectangle origin and size, or selects the full screen, then steps through every pixel once in row-major order.
- Emits screen x/y, a sprite-memory read address (optionally horizontally mirrored), and a plot strobe with backpressure.
- Sits between the game FSM (start/done handshake) and the colour mux / VGA adapter; supersedes the fixed 40x40 and whole-screen counters.

Parameters:
- X_W, 8, screen x coordinate width
- Y_W, 7, screen y coordinate width
- SCREEN_W, 160, visible columns; x >= SCREEN_W is off-screen
- SCREEN_H, 120, visible rows; y >= SCREEN_H is off-screen
- ADDR_W, 15, sprite/frame memory address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin scan; sampled only in IDLE
- mode  in  2  00 full screen, 01 rectangle, 10 rectangle mirrored, 11 reserved (behaves as 01)
- x_origin  in  X_W  rectangle left column
- y_origin  in  Y_W  rectangle top row
- rect_w  in  X_W  rectangle width in pixels
- rect_h  in  Y_W  rectangle height in pixels
- abort  in  1  cancel the scan in progress
- stall  in  1  downstream not ready; holds the current pixel
- x  out  X_W  screen column of the current pixel
- y  out  Y_W  screen row of the current pixel
- addr  out  ADDR_W  memory address of the current pixel
- plot  out  1  current pixel valid and on-screen
- busy  out  1  high in LOAD and SCAN
- done  out  1  one-cycle pulse when the scan completes

Behaviour:
- Reset (resetn=0, async): state IDLE; x=0, y=0, addr=0, plot=0, busy=0, done=0; latched geometry cleared. Reset mid-scan abandons the scan with no done pulse.
- States: IDLE -> LOAD -> SCAN -> DONE -> IDLE.
- IDLE:
  - start=1 -> LOAD.
  - mode=00 latches origin (0,0) and size SCREEN_W x SCREEN_H; x_origin, y_origin, rect_w, rect_h are ignored.
  - Any other mode latches the inputs, so later input changes have no effect on this scan.
- LOAD (1 cycle):
  - busy=1; col=0, row=0; addr base=0.
  - If the latched w==0 or h==0 -> DONE, with no plot ever asserted.
  - Otherwise -> SCAN.
- SCAN:
  - x = x_org+col and y = y_org+row, computed at X_W+1 / Y_W+1 bits then truncated for output.
  - plot=1 only if the unwidened sums are < SCREEN_W and < SCREEN_H; off-screen pixels still consume one cycle and advance addr (clipping, not skipping).
  - Unmirrored: addr = row*w + col. Mirrored: addr = row*w + (w-1-col). Both are formed from an incrementally updated row base (base += w at each row end), with no multiplier.
  - Pixel accepted when stall=0. On acceptance: col increments; when col==w-1, col=0 and row increments.
  - When the accepted pixel is (w-1, h-1) -> DONE.
  - stall=1 holds col, row, x, y, addr and plot unchanged.
- DONE (1 cycle): done=1, busy=0, plot=0 -> IDLE. A start in the DONE cycle is ignored.
- abort=1 in LOAD or SCAN -> IDLE next cycle; plot=0, busy=0, no done. abort has priority over stall and over the last-pixel transition.
- start while busy is ignored.
- Latency:
  - start seen at edge N; first pixel is presented in cycle N+2.
  - With no stalls, done is asserted exactly w*h cycles after the first pixel, i.e. total start-to-done = 2 + w*h cycles.
- x, y and addr hold their last values in IDLE and DONE.

Decomposition:
- Package rect_scan_pkg:
  - mode constants MODE_FULL, MODE_RECT, MODE_MIRROR
  - state enum S_IDLE, S_LOAD, S_SCAN, S_DONE
  - default SCREEN_W and SCREEN_H
- One sub-module, scan_axis_counter: a width-parametrised counter with clear, enable, terminal-count flag and wrap. It is instanced twice, as the column counter and as the row counter (the row counter enabled by the column terminal count).

Test Plan:
- Full screen: mode=00, start pulse, stall=0 -> first pixel (0,0) addr 0; 19200 plot cycles; last pixel (159,119) addr 19199; done 19202 cycles after start.
- Rectangle: mode=01, origin (36,30), size 4x3 -> x sequence 36..39 repeated on rows 30..32; addr 0..11; exactly 12 plots; one done pulse.
- Mirror: mode=10, origin (90,30), size 4x2 -> row 0 addr 3,2,1,0 at x 90..93; row 1 addr 7,6,5,4.
- Clipping and zero size:
  - origin (158,118), size 4x4 -> plot high only for x in {158,159} and y in {118,119} (4 pixels); addr still walks 0..15.
  - rect_w=0 -> done two cycles after start, plot never asserted.
- Stall: 2x2 scan with stall held 3 cycles on pixel (1,0) -> x, y, addr and plot frozen for those 3 cycles; done delayed by exactly 3 cycles.
- Abort and reset:
  - abort during pixel 5 -> IDLE next cycle, no done; a subsequent start runs a full scan from addr 0.
  - resetn low mid-scan -> all outputs return to their reset values immediately (asynchronously).

Source files
------------

// File: rtl/rect_scan_pkg.sv
// Shared constants and types for the raster-scan coordinate generator.
// Mode encodings, FSM states and default screen geometry.
package rect_scan_pkg;

   localparam logic [1:0] MODE_FULL   = 2'b00;
   localparam logic [1:0] MODE_RECT   = 2'b01;
   localparam logic [1:0] MODE_MIRROR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SCAN,
      S_DONE
   } state_t;

   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/rect_scan_gen_if.sv
// Control/pixel bundle between the game FSM, the scan generator
// and the colour mux / VGA adapter.
interface rect_scan_gen_if #(
   parameter int X_W    = 8,
   parameter int Y_W    = 7,
   parameter int ADDR_W = 15
) ();

   logic              start;
   logic [1:0]        mode;
   logic [X_W-1:0]    x_origin;
   logic [Y_W-1:0]    y_origin;
   logic [X_W-1:0]    rect_w;
   logic [Y_W-1:0]    rect_h;
   logic              abort;
   logic              stall;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [ADDR_W-1:0] addr;
   logic              plot;
   logic              busy;
   logic              done;

   modport master (
      output start, mode, x_origin, y_origin,
      output rect_w, rect_h, abort, stall,
      input  x, y, addr, plot, busy, done
   );

   modport slave (
      input  start, mode, x_origin, y_origin,
      input  rect_w, rect_h, abort, stall,
      output x, y, addr, plot, busy, done
   );

endinterface

// File: rtl/scan_axis_counter.sv
// Single scan axis: counts 0..top_val, wrapping to zero on enable at
// terminal count; clear has priority over enable.
module scan_axis_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] top_val,
   output logic [W-1:0] cnt,
   output logic         tc
);

   assign tc = (cnt == top_val);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/rect_scan_gen.sv
// Raster-scan coordinate generator: walks a latched rectangle (or the
// full screen) in row-major order, emitting x/y, sprite address and plot.
module rect_scan_gen
   import rect_scan_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H,
   parameter int ADDR_W   = 15
) (
   input  logic           clk,
   input  logic           resetn,
   rect_scan_gen_if.slave bus
);

   localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

   state_t            state;
   state_t            nxt;
   logic [X_W-1:0]    x_org;
   logic [Y_W-1:0]    y_org;
   logic [X_W-1:0]    w;
   logic [Y_W-1:0]    h;
   logic              mirror;
   logic [ADDR_W-1:0] base;
   logic [X_W-1:0]    col;
   logic [Y_W-1:0]    row;
   logic              col_tc;
   logic              row_tc;
   logic              accept;
   logic              last_px;
   logic              col_en;
   logic              row_en;
   logic              clr;
   logic [X_W:0]      xs;
   logic [Y_W:0]      ys;
   logic [X_W-1:0]    off_x;

   assign accept  = (state == S_SCAN) && !bus.abort && !bus.stall;
   assign last_px = col_tc && row_tc;
   // Counters freeze on the last pixel so x/y/addr hold through DONE
   assign col_en  = accept && !last_px;
   assign row_en  = col_en && col_tc;
   assign clr     = (state == S_LOAD);

   scan_axis_counter #(.W(X_W)) u_col (
      .clk     (clk),
      .rst_n   (resetn),
      .clr     (clr),
      .en      (col_en),
      .top_val (w - X_W'(1)),
      .cnt     (col),
      .tc      (col_tc)
   );

   scan_axis_counter #(.W(Y_W)) u_row (
      .clk     (clk),
      .rst_n   (resetn),
      .clr     (clr),
      .en      (row_en),
      .top_val (h - Y_W'(1)),
      .cnt     (row),
      .tc      (row_tc)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_org  <= '0;
         y_org  <= '0;
         w      <= '0;
         h      <= '0;
         mirror <= 1'b0;
      end else if (state == S_IDLE && bus.start) begin
         unique case (1'b1)
            (bus.mode == MODE_FULL): begin
               x_org  <= '0;
               y_org  <= '0;
               w      <= X_W'(SCREEN_W);
               h      <= Y_W'(SCREEN_H);
               mirror <= 1'b0;
            end
            default: begin
               x_org  <= bus.x_origin;
               y_org  <= bus.y_origin;
               w      <= bus.rect_w;
               h      <= bus.rect_h;
               mirror <= (bus.mode == MODE_MIRROR);
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         base <= '0;
      end else if (clr) begin
         base <= '0;
      end else if (row_en) begin
         base <= base + ADDR_W'(w);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: begin
            if (bus.start) nxt = S_LOAD;
         end
         S_LOAD: begin
            if (bus.abort)               nxt = S_IDLE;
            else if (w == '0 || h == '0) nxt = S_DONE;
            else                         nxt = S_SCAN;
         end
         S_SCAN: begin
            if (bus.abort)                   nxt = S_IDLE;
            else if (!bus.stall && last_px)  nxt = S_DONE;
         end
         S_DONE: begin
            nxt = S_IDLE;
         end
         default: begin
            nxt = S_IDLE;
         end
      endcase
   end

   assign xs    = {1'b0, x_org} + {1'b0, col};
   assign ys    = {1'b0, y_org} + {1'b0, row};
   assign off_x = mirror ? (w - X_W'(1) - col) : col;

   assign bus.x    = xs[X_W-1:0];
   assign bus.y    = ys[Y_W-1:0];
   assign bus.addr = base + ADDR_W'(off_x);
   assign bus.plot = (state == S_SCAN) && (xs < SW) && (ys < SH);
   assign bus.busy = (state == S_LOAD) || (state == S_SCAN);
   assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_rect_scan_gen.sv
// Scoreboard bench for rect_scan_gen: directed scans push expected
// pixels; a negedge monitor pops and compares each accepted plot.
module tb_rect_scan_gen;
   import rect_scan_pkg::*;

   typedef struct packed {
      logic [7:0]  x;
      logic [6:0]  y;
      logic [14:0] addr;
   } pix_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   plot_cnt = 0;
   int   done_cnt = 0;
   pix_t sb[$];

   rect_scan_gen_if #(.X_W(8), .Y_W(7), .ADDR_W(15)) bus ();

   rect_scan_gen #(
      .X_W      (8),
      .Y_W      (7),
      .SCREEN_W (160),
      .SCREEN_H (120),
      .ADDR_W   (15)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, logic [31:0] act,
                                 logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endfunction

   function automatic void push(int px, int py, int pa);
      pix_t p;
      p.x    = 8'(px);
      p.y    = 7'(py);
      p.addr = 15'(pa);
      sb.push_back(p);
   endfunction

   always @(negedge clk) begin
      if (resetn) begin
         if (bus.plot && !bus.stall) begin
            pix_t e;
            plot_cnt++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pix_unexpected actual=%0h expected=none",
                        {bus.x, bus.y, bus.addr});
            end else begin
               e = sb.pop_front();
               check("pix", {2'b0, bus.x, bus.y, bus.addr}, {2'b0, e});
            end
         end
         if (bus.done) done_cnt++;
      end
   end

   task automatic start_scan(input logic [1:0] m, input int xo,
                             input int yo, input int w, input int h,
                             output int e0);
      bus.mode     = m;
      bus.x_origin = 8'(xo);
      bus.y_origin = 7'(yo);
      bus.rect_w   = 8'(w);
      bus.rect_h   = 7'(h);
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      bus.start    = 1'b0;
      // scrambled inputs must not affect the scan already latched
      bus.mode     = MODE_FULL;
      bus.x_origin = 8'd5;
      bus.y_origin = 7'd5;
      bus.rect_w   = 8'd1;
      bus.rect_h   = 7'd1;
   endtask

   // done appears after edge e0+1+w*h (+stall cycles)
   task automatic wait_done(input int e0, input int delta, input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < delta + 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            check({nm, "_lat"}, 32'(cyc - e0), 32'(delta));
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_done expected=done", nm);
      end
      @(negedge clk);
      check({nm, "_idle"}, {29'b0, bus.busy, bus.done, bus.plot}, 32'd0);
   endtask

   task automatic finish_case(input string nm, input int pc0, input int dc0,
                              input int plots, input int dones);
      check({nm, "_plots"}, 32'(plot_cnt - pc0), 32'(plots));
      check({nm, "_dones"}, 32'(done_cnt - dc0), 32'(dones));
      check({nm, "_sb_left"}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      int e0;
      int pc0;
      int dc0;
      int mir_a [8] = '{3, 2, 1, 0, 7, 6, 5, 4};

      bus.start    = 1'b0;
      bus.mode     = MODE_FULL;
      bus.x_origin = '0;
      bus.y_origin = '0;
      bus.rect_w   = '0;
      bus.rect_h   = '0;
      bus.abort    = 1'b0;
      bus.stall    = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("reset_state",
            {1'b0, bus.x, bus.y, bus.addr, bus.plot, bus.busy, bus.done},
            32'd0);

      // full screen
      pc0 = plot_cnt;
      dc0 = done_cnt;
      for (int yy = 0; yy < 120; yy++)
         for (int xx = 0; xx < 160; xx++)
            push(xx, yy, yy * 160 + xx);
      start_scan(MODE_FULL, 9, 9, 9, 9, e0);
      wait_done(e0, 19201, "full");
      finish_case("full", pc0, dc0, 19200, 1);

      // rectangle 4x3 at (36,30)
      pc0 = plot_cnt;
      dc0 = done_cnt;
      for (int i = 0; i < 12; i++) push(36 + i % 4, 30 + i / 4, i);
      start_scan(MODE_RECT, 36, 30, 4, 3, e0);
      wait_done(e0, 13, "rect");
      finish_case("rect", pc0, dc0, 12, 1);

      // mirrored 4x2 at (90,30)
      pc0 = plot_cnt;
      dc0 = done_cnt;
      for (int i = 0; i < 8; i++) push(90 + i % 4, 30 + i / 4, mir_a[i]);
      start_scan(MODE_MIRROR, 90, 30, 4, 2, e0);
      wait_done(e0, 9, "mirror");
      finish_case("mirror", pc0, dc0, 8, 1);

      // reserved mode acts as plain rectangle
      pc0 = plot_cnt;
      dc0 = done_cnt;
      push(0, 0, 0);
      push(1, 0, 1);
      start_scan(2'b11, 0, 0, 2, 1, e0);
      wait_done(e0, 3, "rsvd");
      finish_case("rsvd", pc0, dc0, 2, 1);

      // clipped 4x4 at (158,118): only 4 visible, addr still walks
      pc0 = plot_cnt;
      dc0 = done_cnt;
      push(158, 118, 0);
      push(159, 118, 1);
      push(158, 119, 4);
      push(159, 119, 5);
      start_scan(MODE_RECT, 158, 118, 4, 4, e0);
      wait_done(e0, 17, "clip");
      finish_case("clip", pc0, dc0, 4, 1);

      // zero width
      pc0 = plot_cnt;
      dc0 = done_cnt;
      start_scan(MODE_RECT, 10, 10, 0, 3, e0);
      wait_done(e0, 1, "zero");
      finish_case("zero", pc0, dc0, 0, 1);

      // stall 3 cycles on pixel (1,0) of a 2x2
      pc0 = plot_cnt;
      dc0 = done_cnt;
      push(10, 20, 0);
      push(11, 20, 1);
      push(10, 21, 2);
      push(11, 21, 3);
      start_scan(MODE_RECT, 10, 20, 2, 2, e0);
      repeat (2) @(posedge clk);
      #1 bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_hold", {1'b0, bus.x, bus.y, bus.addr, bus.plot},
               {1'b0, 8'd11, 7'd20, 15'd1, 1'b1});
         @(posedge clk);
         #1;
      end
      bus.stall = 1'b0;
      wait_done(e0, 8, "stall");
      finish_case("stall", pc0, dc0, 4, 1);

      // abort during pixel 5, then a fresh scan from addr 0
      pc0 = plot_cnt;
      dc0 = done_cnt;
      for (int i = 0; i < 6; i++) push(36 + i % 4, 30 + i / 4, i);
      start_scan(MODE_RECT, 36, 30, 4, 3, e0);
      repeat (6) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      check("abort_idle", {30'b0, bus.busy, bus.plot}, 32'd0);
      repeat (3) @(negedge clk);
      finish_case("abort", pc0, dc0, 6, 0);
      pc0 = plot_cnt;
      dc0 = done_cnt;
      for (int i = 0; i < 12; i++) push(36 + i % 4, 30 + i / 4, i);
      start_scan(MODE_RECT, 36, 30, 4, 3, e0);
      wait_done(e0, 13, "rerun");
      finish_case("rerun", pc0, dc0, 12, 1);

      // async reset mid-scan
      dc0 = done_cnt;
      for (int i = 0; i < 12; i++) push(36 + i % 4, 30 + i / 4, i);
      start_scan(MODE_RECT, 36, 30, 4, 3, e0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1 resetn = 1'b0;
      #1;
      check("async_reset",
            {1'b0, bus.x, bus.y, bus.addr, bus.plot, bus.busy, bus.done},
            32'd0);
      sb.delete();
      @(posedge clk);
      #1 resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_no_done", 32'(done_cnt - dc0), 32'd0);
      check("reset_idle", {30'b0, bus.busy, bus.plot}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
